// File: rtl/cpu_controller.sv
// Moore-FSM control unit for the 16-bit CPU datapath: fetches into IR, decodes,
// and sequences regfile/ALU/memory strobes for each instruction class.
module cpu_controller #(
  parameter logic HALT_ON_ILLEGAL = 1'b1
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic [15:0] mdata,
  output logic [2:0]  w_addr,
  output logic        w_en,
  output logic [2:0]  r_addr,
  output logic        en_A,
  output logic        en_B,
  output logic [1:0]  shift_op,
  output logic        sel_A,
  output logic        sel_B,
  output logic [1:0]  ALU_op,
  output logic        en_C,
  output logic        en_status,
  output logic [1:0]  wb_sel,
  output logic [15:0] sximm8,
  output logic [15:0] sximm5,
  output logic        load_pc,
  output logic        reset_pc,
  output logic        addr_sel,
  output logic        load_addr,
  output logic [1:0]  mem_cmd,
  output logic        halted
);

  typedef enum logic [4:0] {
    S_RST, S_IF1, S_IF2, S_UPD_PC, S_DECODE, S_WR_IMM, S_GET_A, S_GET_B,
    S_EXEC, S_WR_RD, S_ADDR, S_LD_ADDR, S_MRD1, S_MRD2, S_GET_RD, S_PASS,
    S_MWR, S_HALT
  } state_t;

  typedef enum logic [3:0] {
    I_MOV_IMM, I_MOV_REG, I_ADD, I_CMP, I_AND, I_MVN, I_LDR, I_STR, I_HALT, I_ILL
  } instr_t;

  localparam logic [1:0] MEM_NONE  = 2'b00;
  localparam logic [1:0] MEM_READ  = 2'b01;
  localparam logic [1:0] MEM_WRITE = 2'b10;
  localparam logic [1:0] WB_C      = 2'b00;
  localparam logic [1:0] WB_IMM8   = 2'b10;
  localparam logic [1:0] WB_MDATA  = 2'b11;
  localparam logic [1:0] ALU_ADD   = 2'b00;
  localparam logic [1:0] ALU_SUB   = 2'b01;
  localparam logic [1:0] ALU_NOTB  = 2'b11;

  state_t      state, next_state;
  instr_t      instr;
  logic [15:0] ir;

  logic [2:0] opcode;
  logic [1:0] op;
  logic [2:0] rn, rd, rm;
  logic [1:0] sh;

  assign opcode = ir[15:13];
  assign op     = ir[12:11];
  assign rn     = ir[10:8];
  assign rd     = ir[7:5];
  assign sh     = ir[4:3];
  assign rm     = ir[2:0];

  assign sximm8 = {{8{ir[7]}}, ir[7:0]};
  assign sximm5 = {{11{ir[4]}}, ir[4:0]};

  always_comb begin
    instr = I_ILL;
    case (opcode)
      3'b110: begin
        if (op == 2'b10)      instr = I_MOV_IMM;
        else if (op == 2'b00) instr = I_MOV_REG;
      end
      3'b101: begin
        case (op)
          2'b00:   instr = I_ADD;
          2'b01:   instr = I_CMP;
          2'b10:   instr = I_AND;
          default: instr = I_MVN;
        endcase
      end
      3'b011:  if (op == 2'b00) instr = I_LDR;
      3'b100:  if (op == 2'b00) instr = I_STR;
      3'b111:  instr = I_HALT;
      default: instr = I_ILL;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state <= S_RST;
      ir    <= '0;
    end else begin
      state <= next_state;
      if (state == S_IF2) ir <= mdata;
    end
  end

  always_comb begin
    next_state = S_RST;
    w_addr     = '0;
    w_en       = 1'b0;
    r_addr     = '0;
    en_A       = 1'b0;
    en_B       = 1'b0;
    shift_op   = '0;
    sel_A      = 1'b0;
    sel_B      = 1'b0;
    ALU_op     = ALU_ADD;
    en_C       = 1'b0;
    en_status  = 1'b0;
    wb_sel     = WB_C;
    load_pc    = 1'b0;
    reset_pc   = 1'b0;
    addr_sel   = 1'b0;
    load_addr  = 1'b0;
    mem_cmd    = MEM_NONE;
    halted     = 1'b0;

    case (state)
      S_RST: begin
        reset_pc   = 1'b1;
        load_pc    = 1'b1;
        next_state = S_IF1;
      end
      S_IF1: begin
        addr_sel   = 1'b1;
        mem_cmd    = MEM_READ;
        next_state = S_IF2;
      end
      S_IF2: begin
        addr_sel   = 1'b1;
        mem_cmd    = MEM_READ;
        next_state = S_UPD_PC;
      end
      S_UPD_PC: begin
        load_pc    = 1'b1;
        next_state = S_DECODE;
      end
      S_DECODE: begin
        case (instr)
          I_MOV_IMM:                   next_state = S_WR_IMM;
          I_MOV_REG, I_MVN:            next_state = S_GET_B;
          I_ADD, I_AND, I_CMP,
          I_LDR, I_STR:                next_state = S_GET_A;
          I_HALT:                      next_state = S_HALT;
          default: next_state = HALT_ON_ILLEGAL ? S_HALT : S_IF1;
        endcase
      end
      S_WR_IMM: begin
        w_addr     = rn;
        wb_sel     = WB_IMM8;
        w_en       = 1'b1;
        next_state = S_IF1;
      end
      S_GET_A: begin
        r_addr     = rn;
        en_A       = 1'b1;
        next_state = (instr == I_LDR || instr == I_STR) ? S_ADDR : S_GET_B;
      end
      S_GET_B: begin
        r_addr     = rm;
        en_B       = 1'b1;
        if (instr inside {I_MOV_REG, I_ADD, I_CMP, I_AND, I_MVN}) shift_op = sh;
        next_state = S_EXEC;
      end
      S_EXEC: begin
        en_C       = 1'b1;
        next_state = S_WR_RD;
        case (instr)
          I_MOV_REG: begin
            sel_A  = 1'b1;
            ALU_op = ALU_ADD;
          end
          I_MVN:   ALU_op = ALU_NOTB;
          I_CMP: begin
            ALU_op     = ALU_SUB;
            en_status  = 1'b1;
            en_C       = 1'b0;
            next_state = S_IF1;
          end
          default: ALU_op = op;
        endcase
      end
      S_WR_RD: begin
        w_addr     = rd;
        wb_sel     = WB_C;
        w_en       = 1'b1;
        next_state = S_IF1;
      end
      S_ADDR: begin
        sel_B      = 1'b1;
        ALU_op     = ALU_ADD;
        en_C       = 1'b1;
        next_state = S_LD_ADDR;
      end
      S_LD_ADDR: begin
        load_addr  = 1'b1;
        next_state = (instr == I_LDR) ? S_MRD1 : S_GET_RD;
      end
      S_MRD1: begin
        mem_cmd    = MEM_READ;
        next_state = S_MRD2;
      end
      S_MRD2: begin
        mem_cmd    = MEM_READ;
        w_addr     = rd;
        wb_sel     = WB_MDATA;
        w_en       = 1'b1;
        next_state = S_IF1;
      end
      S_GET_RD: begin
        r_addr     = rd;
        en_B       = 1'b1;
        next_state = S_PASS;
      end
      S_PASS: begin
        sel_A      = 1'b1;
        ALU_op     = ALU_ADD;
        en_C       = 1'b1;
        next_state = S_MWR;
      end
      S_MWR: begin
        mem_cmd    = MEM_WRITE;
        next_state = S_IF1;
      end
      S_HALT: begin
        halted     = 1'b1;
        next_state = S_HALT;
      end
      // Unencoded state values recover through RST rather than locking up.
      default: next_state = S_RST;
    endcase
  end

endmodule
